break_beam_array: RTL

//  Multi-channel IR break-beam front end. Synchronises NUM_CH raw receiver pins, samples them on an

---
 rtl/break_beam_pkg.sv | 20 ++
 rtl/break_beam_chan.sv | 155 +++++++++++++++
 rtl/break_beam_array.sv | 69 ++++++
 3 files changed

// File: rtl/break_beam_pkg.sv
// break_beam_pkg: shared state type, counter widths and decode helper for
// the break-beam front end (break_beam_chan, break_beam_array).
package break_beam_pkg;

    typedef enum logic [1:0] {
        INTACT,
        CONFIRM_BREAK,
        BROKEN,
        CONFIRM_CLEAR
    } bb_state_t;

    localparam int unsigned DCNT_W  = 8;
    localparam int unsigned STUCK_W = 16;

    // The beam reads as broken until a clear has been fully confirmed.
    function automatic logic is_broken(input bb_state_t s);
        return (s == BROKEN) || (s == CONFIRM_CLEAR);
    endfunction

endpackage

// File: rtl/break_beam_chan.sv
// break_beam_chan: one sensor channel - synchroniser, tick-sampled debounce FSM,
// saturating break counter and toggle LED. Stuck detection needs BREAK_STUCK_FAULT_EN.
module break_beam_chan
    import break_beam_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N  = 4,
    parameter int unsigned CNT_W       = 16,
    parameter logic        BROKEN_LVL  = 1'b0,
    parameter int unsigned STUCK_TICKS = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             sense_i,
    input  logic             clr_i,
    output logic             broken_o,
    output logic             pulse_o,
    output logic             led_o,
    output logic [CNT_W-1:0] count_o,
    output logic             fault_o
);

    if (DEBOUNCE_N < 1 || DEBOUNCE_N > 255 || STUCK_TICKS < 1 || STUCK_TICKS > 65535) begin : g_bad_cfg
        $error("break_beam_chan: DEBOUNCE_N or STUCK_TICKS out of range");
    end

    localparam logic [DCNT_W-1:0] DEB_N = DCNT_W'(DEBOUNCE_N);

    logic              sync1_q, sync2_q;
    logic              b;
    bb_state_t         state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic              brk_d;
    logic              broken_q, pulse_q, led_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= ~BROKEN_LVL;
            sync2_q <= ~BROKEN_LVL;
        end else begin
            sync1_q <= sense_i;
            sync2_q <= sync1_q;
        end
    end

    assign b        = (sync2_q == BROKEN_LVL);
    assign dcnt_inc = dcnt_q + DCNT_W'(1);

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        brk_d   = 1'b0;
        if (tick_i) begin
            unique case (state_q)
                INTACT: begin
                    if (b) begin
                        if (DEBOUNCE_N == 1) begin
                            state_d = BROKEN;
                            brk_d   = 1'b1;
                        end else begin
                            state_d = CONFIRM_BREAK;
                            dcnt_d  = DCNT_W'(1);
                        end
                    end
                end
                CONFIRM_BREAK: begin
                    if (!b) begin
                        state_d = INTACT;
                        dcnt_d  = '0;
                    end else if (dcnt_inc == DEB_N) begin
                        state_d = BROKEN;
                        dcnt_d  = '0;
                        brk_d   = 1'b1;
                    end else begin
                        dcnt_d  = dcnt_inc;
                    end
                end
                BROKEN: begin
                    if (!b) begin
                        if (DEBOUNCE_N == 1) begin
                            state_d = INTACT;
                        end else begin
                            state_d = CONFIRM_CLEAR;
                            dcnt_d  = DCNT_W'(1);
                        end
                    end
                end
                CONFIRM_CLEAR: begin
                    if (b) begin
                        state_d = BROKEN;
                        dcnt_d  = '0;
                    end else if (dcnt_inc == DEB_N) begin
                        state_d = INTACT;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d  = dcnt_inc;
                    end
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle break; pulse and LED still fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INTACT;
            dcnt_q   <= '0;
            broken_q <= 1'b0;
            pulse_q  <= 1'b0;
            led_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            broken_q <= is_broken(state_d);
            pulse_q  <= brk_d;
            if (brk_d) led_q <= ~led_q;
            if (clr_i) count_q <= '0;
            else if (brk_d && count_q != '1) count_q <= count_q + CNT_W'(1);
        end
    end

    assign broken_o = broken_q;
    assign pulse_o  = pulse_q;
    assign led_o    = led_q;
    assign count_o  = count_q;

`ifdef BREAK_STUCK_FAULT_EN
    localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_TICKS);

    logic [STUCK_W-1:0] stuck_q, stuck_inc;
    logic               fault_q;

    assign stuck_inc = stuck_q + STUCK_W'(1);

    // Fault survives a CONFIRM_CLEAR bounce; only a confirmed clear releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state_q != BROKEN) stuck_q <= '0;
            else if (tick_i && stuck_q != '1) stuck_q <= stuck_inc;
            if (state_q == INTACT) fault_q <= 1'b0;
            else if (state_q == BROKEN && tick_i && stuck_inc == STUCK_LIM) fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

endmodule

// File: rtl/break_beam_array.sv
// break_beam_array: NUM_CH-channel IR break-beam front end with a shared sample-tick
// divider and run LED. Define BREAK_STUCK_FAULT_EN to build per-channel stuck detection.
module break_beam_array
    import break_beam_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TICK_DIV    = 50_000,
    parameter int unsigned DEBOUNCE_N  = 4,
    parameter int unsigned CNT_W       = 16,
    parameter logic        BROKEN_LVL  = 1'b0,
    parameter int unsigned STUCK_TICKS = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       sense,
    input  logic                    clr_counts,
    output logic                    led_run,
    output logic [NUM_CH-1:0]       broken,
    output logic [NUM_CH-1:0]       break_pulse,
    output logic [NUM_CH-1:0]       led_toggle,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       fault
);

    if (NUM_CH < 1 || NUM_CH > 16 || TICK_DIV < 2) begin : g_bad_cfg
        $error("break_beam_array: NUM_CH or TICK_DIV out of range");
    end

    localparam int unsigned TW = $clog2(TICK_DIV);

    logic [TW-1:0] tcnt_q;
    logic          tick;
    logic          led_run_q;

    assign tick = (tcnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q    <= '0;
            led_run_q <= 1'b0;
        end else begin
            tcnt_q    <= tick ? '0 : tcnt_q + TW'(1);
            led_run_q <= 1'b1;
        end
    end

    assign led_run = led_run_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        break_beam_chan #(
            .DEBOUNCE_N (DEBOUNCE_N),
            .CNT_W      (CNT_W),
            .BROKEN_LVL (BROKEN_LVL),
            .STUCK_TICKS(STUCK_TICKS)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .sense_i (sense[i]),
            .clr_i   (clr_counts),
            .broken_o(broken[i]),
            .pulse_o (break_pulse[i]),
            .led_o   (led_toggle[i]),
            .count_o (count[i*CNT_W +: CNT_W]),
            .fault_o (fault[i])
        );
    end

endmodule
